// File: rtl/j1a_pkg.sv
// j1a_pkg: loader state encoding, frame magic byte and j1 IO address bit positions
package j1a_pkg;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM, ERR, RUN} ld_state_t;
    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int IO_UART_BIT = 12;
    localparam int IO_RAM_BIT = 12;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: UART0 RX (valid/data/rd), j1 write bus (mem_wr/mem_addr/dout), ram_prog write port (wr/addr/din)
interface prog_loader_if #(parameter int AW = 11);
    logic          uart0_valid;
    logic [7:0]    uart0_data;
    logic          uart0_rd;
    logic          cpu_mem_wr;
    logic [15:0]   cpu_mem_addr;
    logic [15:0]   cpu_dout;
    logic          prog_wr;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_din;
    modport master (
        output uart0_valid, uart0_data, cpu_mem_wr, cpu_mem_addr, cpu_dout,
        input  uart0_rd, prog_wr, prog_addr, prog_din
    );
    modport slave (
        input  uart0_valid, uart0_data, cpu_mem_wr, cpu_mem_addr, cpu_dout,
        output uart0_rd, prog_wr, prog_addr, prog_din
    );
endinterface

// File: rtl/rx_byte_take.sv
// rx_byte_take: takes one RX byte per valid (en/valid/data in; rd pulse, stb, byte_q out), skipping the cycle after each rd
module rx_byte_take (
    input  logic       clk,
    input  logic       resetq,
    input  logic       en,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       rd,
    output logic       stb,
    output logic [7:0] byte_q
);
    logic take;
    assign take = en & valid & ~rd;
    assign stb = rd;
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            rd <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            rd <= take;
            if (take) byte_q <= data;
        end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART0 image loader for ram_prog (clk, resetq, bus: UART/CPU/ram_prog; cpu_resetq, load_done, load_err)
module prog_loader import j1a_pkg::*; #(
    parameter int DEPTH = 2048,
    parameter int AW = 11,
    parameter int BOOT_WAIT = 1000000,
    parameter int BYTE_TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         resetq,
    prog_loader_if.slave bus,
    output logic         cpu_resetq,
    output logic         load_done,
    output logic         load_err
);
    localparam int BW = $clog2(BOOT_WAIT + 1);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    ld_state_t     state;
    logic [BW-1:0] boot_cnt;
    logic [TW-1:0] tmr;
    logic [7:0]    cnt_lo, lo, csum, rx_byte;
    logic [AW:0]   rem;
    logic [AW-1:0] addr, ld_addr;
    logic [15:0]   ld_din, cnt;
    logic          ld_wr, stb, rx_en, framing, timeout, run, unused_ok;
    assign run = state == RUN;
    assign rx_en = state != ERR && !run;
    assign framing = state inside {CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM};
    assign timeout = framing && !stb && tmr == TW'(BYTE_TIMEOUT - 1);
    assign cnt = {rx_byte, cnt_lo};
    rx_byte_take u_rx (
        .clk(clk),
        .resetq(resetq),
        .en(rx_en),
        .valid(bus.uart0_valid),
        .data(bus.uart0_data),
        .rd(bus.uart0_rd),
        .stb(stb),
        .byte_q(rx_byte)
    );
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            state <= IDLE;
            boot_cnt <= '0;
            tmr <= '0;
            cnt_lo <= '0;
            lo <= '0;
            csum <= '0;
            rem <= '0;
            addr <= '0;
            ld_wr <= 1'b0;
            ld_addr <= '0;
            ld_din <= '0;
            cpu_resetq <= 1'b0;
            load_done <= 1'b0;
            load_err <= 1'b0;
        end else begin
            ld_wr <= 1'b0;
            load_err <= 1'b0;
            tmr <= (framing && !stb) ? tmr + 1'b1 : '0;
            if (timeout) begin
                state <= ERR;
                load_err <= 1'b1;
            end else case (state)
                IDLE: begin
                    boot_cnt <= boot_cnt + 1'b1;
                    if (stb && rx_byte == LOADER_MAGIC) state <= CNT_LO;
                    else if (boot_cnt >= BW'(BOOT_WAIT - 1)) begin
                        state <= RUN;
                        cpu_resetq <= 1'b1;
                        load_done <= 1'b1;
                    end
                end
                CNT_LO: if (stb) begin
                    cnt_lo <= rx_byte;
                    state <= CNT_HI;
                end
                // CNT is bounded here, so the word address can never wrap mid-frame
                CNT_HI: if (stb) begin
                    addr <= '0;
                    csum <= '0;
                    rem <= (AW+1)'(cnt);
                    if (32'(cnt) > DEPTH) begin
                        state <= ERR;
                        load_err <= 1'b1;
                    end else state <= cnt == 16'd0 ? CSUM : DAT_LO;
                end
                DAT_LO: if (stb) begin
                    lo <= rx_byte;
                    csum <= csum + rx_byte;
                    state <= DAT_HI;
                end
                DAT_HI: if (stb) begin
                    ld_wr <= 1'b1;
                    ld_addr <= addr;
                    ld_din <= {rx_byte, lo};
                    addr <= addr + 1'b1;
                    rem <= rem - 1'b1;
                    csum <= csum + rx_byte;
                    state <= rem == (AW+1)'(1) ? CSUM : DAT_LO;
                end
                CSUM: if (stb) begin
                    if (rx_byte == csum) begin
                        state <= RUN;
                        cpu_resetq <= 1'b1;
                        load_done <= 1'b1;
                    end else begin
                        state <= ERR;
                        load_err <= 1'b1;
                    end
                end
                // boot_cnt is deliberately kept so the fallback boot still happens after bad frames
                ERR: begin
                    addr <= '0;
                    csum <= '0;
                    state <= IDLE;
                end
                default: ;
            endcase
        end
    // once running, the CPU owns ram_prog; IO-space writes never reach it
    assign bus.prog_wr = run ? bus.cpu_mem_wr & ~bus.cpu_mem_addr[IO_RAM_BIT] : ld_wr;
    assign bus.prog_addr = run ? bus.cpu_mem_addr[AW:1] : ld_addr;
    assign bus.prog_din = run ? bus.cpu_dout : ld_din;
    assign unused_ok = ^{bus.cpu_mem_addr, 4'(IO_UART_BIT)};
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequences the program RAM at power-up.
- After reset it holds the J1 in reset and listens on UART0 for a framed image, writing it word by word into ram_prog.
- On a good checksum, or if no frame arrives within a boot window, it releases the CPU and hands the ram_prog write port to the CPU.
- Sits in the top level between the j1 core, the ram_prog write port and the UART0 receive side.

Parameters:
- DEPTH, 2048: program RAM depth in 16-bit words.
- AW, 11: word address width; DEPTH must equal 2**AW.
- BOOT_WAIT, 1000000: cycles to wait in IDLE for the magic byte before booting the existing image.
- BYTE_TIMEOUT, 100000: maximum cycles between bytes once a frame has started.

Ports:
- clk  in  1  system clock
- resetq  in  1  asynchronous active-low reset
- uart0_valid  in  1  RX byte available
- uart0_data  in  8  RX byte
- uart0_rd  out  1  one-cycle pulse; consumes the current RX byte
- cpu_mem_wr  in  1  j1 mem_wr
- cpu_mem_addr  in  16  j1 mem_addr (byte address)
- cpu_dout  in  16  j1 dout
- prog_wr  out  1  ram_prog write enable
- prog_addr  out  AW  ram_prog word address
- prog_din  out  16  ram_prog write data
- cpu_resetq  out  1  active-low reset to j1; low until RUN
- load_done  out  1  high in RUN
- load_err  out  1  one-cycle pulse on frame error

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low (resetq); all state clears asynchronously.
- Reset values: state=IDLE; uart0_rd, prog_wr, load_done, load_err and cpu_resetq = 0; counters and checksum = 0.
- Frame format: 0xA5, CNT_LO, CNT_HI, then CNT words each sent low byte first, then CSUM.
  - CSUM is the 8-bit modular sum of all data bytes only.
  - CNT is 16-bit.
- Byte acceptance:
  - In any receive state with uart0_valid=1, the block registers the byte and pulses uart0_rd for exactly one cycle.
  - uart0_valid is ignored in the cycle after a pulse, so one byte is never consumed twice.
- States:
  - IDLE: a byte of 0xA5 -> CNT_LO. Any other byte is consumed and discarded. Boot counter reaching BOOT_WAIT -> RUN.
  - CNT_LO -> CNT_HI on byte.
  - CNT_HI: on byte, if CNT > DEPTH -> ERR; if CNT = 0 -> CSUM; else -> DAT_LO, with word address = 0 and checksum = 0.
  - DAT_LO: latch low byte -> DAT_HI.
  - DAT_HI: on byte, pulse prog_wr for 1 cycle with prog_addr = current word address and prog_din = {hi, lo}; increment address and decrement remaining count. Remaining count reaching 0 -> CSUM, else -> DAT_LO.
  - CSUM: byte equal to the running checksum -> RUN; otherwise -> ERR.
  - ERR: load_err pulses 1 cycle; reset word address, checksum and byte timer -> IDLE. The boot counter is not reset, so the BOOT_WAIT fallback still applies.
  - RUN: terminal until resetq is asserted. cpu_resetq=1, load_done=1, uart0_rd=0 (the CPU owns the UART).
- Write latency: prog_wr asserts in the cycle after the high byte is accepted.
- Byte timeout: in CNT_LO through CSUM, the byte timer resets on every accepted byte. Reaching BYTE_TIMEOUT -> ERR.
- Arbitration:
  - Outside RUN, prog_* is driven only by the loader. CPU writes cannot occur because the CPU is held in reset.
  - In RUN, a combinational pass-through: prog_wr = cpu_mem_wr & ~cpu_mem_addr[12]; prog_addr = cpu_mem_addr[AW:1]; prog_din = cpu_dout.
- Address wrap: CNT is checked at header time, so the address never wraps. A frame with CNT = DEPTH fills the RAM exactly.
- Reset mid-load: the partial image stays in RAM; the loader returns to IDLE and the CPU stays held.

Decomposition:
- Shared package j1a_pkg holds:
  - the state enum (IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM, ERR, RUN);
  - LOADER_MAGIC = 8'hA5;
  - the IO bit index of the UART (12) and of the RAM select (12).
- One natural sub-module, rx_byte_take: the valid/rd handshake and the guard against consuming a byte twice. It outputs a byte strobe and the registered byte.
- The FSM, counters and arbitration mux stay in prog_loader.

Test Plan:
- Good load: send A5 02 00 34 12 CD AB BE -> prog_wr at address 0 with 0x1234, then at address 1 with 0xABCD; load_done=1, cpu_resetq=1, no load_err.
- Bad checksum: same frame with last byte 0xBF -> exactly one load_err pulse, return to IDLE, cpu_resetq stays 0. Then a good frame -> RUN.
- Oversize: send A5 01 08 (CNT = 0x801) -> load_err without any prog_wr.
- Boot fallback: BOOT_WAIT=100, no RX activity -> cpu_resetq rises at cycle 100. Afterwards, CPU mem_wr with address 0x0006 and dout 0x5555 -> prog_wr=1, prog_addr=3, prog_din=0x5555. Address 0x1006 -> prog_wr=0.
- Timeout and hold: send A5 then stall for BYTE_TIMEOUT cycles -> load_err. With uart0_valid held high for 4 cycles, uart0_rd pulses on cycles 1 and 3 only.
- Async reset mid-data: assert resetq low during DAT_HI -> all outputs 0 immediately; the next frame loads from address 0.
